// File: rtl/clock_gen_if.sv
// clock_gen_if -- control and output bundle for clock_gen.
//   run      : 1 = free-run, 0 = halt request
//   step     : single-period request (rising-edge sensitive)
//   div_ld   : per-channel shadow divisor load strobe
//   div_val  : half-period value written on a load
//   ClockOut : registered divided clocks, one per channel
//   Tick     : one-CLOCK pulse in the first high cycle of each channel
//   Busy     : a single-step period is in progress
// master drives the controls; slave (clock_gen) drives the outputs.
interface clock_gen_if #(
  parameter int NCH  = 2,
  parameter int DIVW = 8
);
  logic            run;
  logic            step;
  logic [NCH-1:0]  div_ld;
  logic [DIVW-1:0] div_val;
  logic [NCH-1:0]  ClockOut;
  logic [NCH-1:0]  Tick;
  logic            Busy;

  modport master (
    output run, step, div_ld, div_val,
    input  ClockOut, Tick, Busy
  );

  modport slave (
    input  run, step, div_ld, div_val,
    output ClockOut, Tick, Busy
  );
endinterface

// File: rtl/clock_gen.sv
// clock_gen -- NCH independent programmable clock dividers with halt/drain
// and optional single-step control.
//   CLOCK : single clock for all logic
//   Reset : asynchronous, active-high
//   bus   : clock_gen_if.slave (run, step, div_ld, div_val in;
//           ClockOut, Tick, Busy out)
// Each channel toggles ClockOut every H CLOCK cycles (H==0 acts as 1).
// Channel i comes out of reset with half-period DIV_INIT<<i.
// Optional feature macro CLOCK_GEN_STEP_EN: adds the STEP state, the step
// edge detector and Busy. Without it step is ignored and Busy is 0.
module clock_gen #(
  parameter int NCH      = 2,
  parameter int DIVW     = 8,
  parameter int DIV_INIT = 1
) (
  input  logic       CLOCK,
  input  logic       Reset,
  clock_gen_if.slave bus
);

`ifdef CLOCK_GEN_STEP_EN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;
`endif

  function automatic logic [DIVW-1:0] eff_half(input logic [DIVW-1:0] h);
    return (h == '0) ? DIVW'(1) : h;
  endfunction

  function automatic logic [DIVW-1:0] rst_half(input int idx);
    return DIVW'(DIV_INIT << idx);
  endfunction

  state_t          state_q [NCH];
  state_t          state_d [NCH];
  logic [DIVW-1:0] cnt_q   [NCH];
  logic [DIVW-1:0] cnt_d   [NCH];
  logic [DIVW-1:0] h_q     [NCH];
  logic [DIVW-1:0] h_d     [NCH];
  logic [DIVW-1:0] hsh_q   [NCH];
  logic [DIVW-1:0] hsh_d   [NCH];
  logic [NCH-1:0]  clk_q, clk_d;
  logic [NCH-1:0]  tick_q, tick_d;
  logic [NCH-1:0]  wrap;

`ifdef CLOCK_GEN_STEP_EN
  logic step_q;
  logic busy_q, busy_d;
  logic all_halt;
  logic step_go;

  always_comb begin
    all_halt = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (state_q[i] != ST_HALT) all_halt = 1'b0;
    end
  end

  // Step is honoured only as a fresh edge with every channel parked.
  assign step_go = bus.step & ~step_q & ~bus.run & all_halt & ~busy_q;

  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (state_d[i] == ST_STEP) busy_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      step_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      step_q <= bus.step;
      busy_q <= busy_d;
    end
  end

  assign bus.Busy = busy_q;
`else
  logic unused_step;
  assign unused_step = bus.step;
  assign bus.Busy    = 1'b0;
`endif

  // A channel counts in every state except HALT.
  always_comb begin
    wrap = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap[i] = (state_q[i] != ST_HALT) &&
                (cnt_q[i] == eff_half(h_q[i]) - DIVW'(1));
    end
  end

  always_comb begin
    clk_d  = clk_q;
    tick_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      h_d[i]     = h_q[i];
      hsh_d[i]   = bus.div_ld[i] ? bus.div_val : hsh_q[i];

      if (state_q[i] != ST_HALT) begin
        if (wrap[i]) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = ~clk_q[i];
          // hsh_d bypass lets a load coincident with the toggle take effect
          // on the very next half-period.
          h_d[i]    = hsh_d[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DIVW'(1);
        end
      end

      // A rising wrap while stopping parks the channel high with cnt=0.
      case (state_q[i])
        ST_RUN: begin
          if (!bus.run) state_d[i] = (wrap[i] && !clk_q[i]) ? ST_HALT : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (bus.run)                    state_d[i] = ST_RUN;
          else if (wrap[i] && !clk_q[i])  state_d[i] = ST_HALT;
        end
        ST_HALT: begin
          h_d[i] = hsh_d[i];
          if (bus.run)      state_d[i] = ST_RUN;
`ifdef CLOCK_GEN_STEP_EN
          else if (step_go) state_d[i] = ST_STEP;
`endif
        end
`ifdef CLOCK_GEN_STEP_EN
        ST_STEP: begin
          if (bus.run)                    state_d[i] = ST_RUN;
          else if (wrap[i] && !clk_q[i])  state_d[i] = ST_HALT;
        end
`endif
        default: state_d[i] = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_RUN;
        cnt_q[i]   <= '0;
        h_q[i]     <= rst_half(i);
        hsh_q[i]   <= rst_half(i);
      end
      clk_q  <= '1;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        h_q[i]     <= h_d[i];
        hsh_q[i]   <= hsh_d[i];
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign bus.ClockOut = clk_q;
  assign bus.Tick     = tick_q;

endmodule
